// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared instruction types plus scheduler read-FSM states and register depth
package instr_register_pkg;
    typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic [4:0] address_t;
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;
    typedef enum logic {RD_IDLE, RD_ADDR} rd_state_t;
    localparam int IR_DEPTH = 32;
endpackage

// File: rtl/instr_register_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from the requester after last
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx
);
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        found = 1'b0;
        idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last) + k) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx = idx;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/instr_register_sched.sv
// instr_register_sched: shares the instr_register write port round-robin and serves committed
// entries oldest-first over a two-cycle read port
module instr_register_sched
    import instr_register_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH = IR_DEPTH,
    localparam int IW = $clog2(NUM_REQ),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  opcode_t            req_opcode    [NUM_REQ],
    input  operand_t           req_operand_a [NUM_REQ],
    input  operand_t           req_operand_b [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    input  logic               rd_req,
    output logic               rd_valid,
    output instruction_t       rd_data,
    output address_t           rd_addr,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic               ir_reset_n,
    output logic               ir_load_en,
    output address_t           ir_write_pointer,
    output opcode_t            ir_opcode,
    output operand_t           ir_operand_a,
    output operand_t           ir_operand_b,
    output address_t           ir_read_pointer,
    input  instruction_t       ir_instruction_word
);
    address_t           wr_ptr, rd_ptr;
    logic [IW-1:0]      rr_last, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               grant_en, hs;
    rd_state_t          rd_state;

    // a load still in flight already owns a slot, so it counts against capacity
    assign grant_en = !reset && ir_reset_n && (count + CW'(ir_load_en) < CW'(DEPTH));
    assign hs = |(gnt & req_valid);
    assign req_ready = gnt;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .enable  (grant_en),
        .last    (rr_last),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_reset_n <= 1'b0;
            ir_load_en <= 1'b0;
            ir_write_pointer <= '0;
            ir_opcode <= ZERO;
            ir_operand_a <= '0;
            ir_operand_b <= '0;
            ir_read_pointer <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_last <= IW'(NUM_REQ - 1);
            rd_state <= RD_IDLE;
            rd_valid <= 1'b0;
            rd_data <= '0;
            rd_addr <= '0;
            count <= '0;
        end else begin
            ir_reset_n <= 1'b1;
            ir_load_en <= hs;
            rd_valid <= 1'b0;
            count <= count + CW'(ir_load_en) - CW'(rd_state == RD_ADDR);
            if (hs) begin
                ir_write_pointer <= wr_ptr;
                ir_opcode <= req_opcode[gnt_idx];
                ir_operand_a <= req_operand_a[gnt_idx];
                ir_operand_b <= req_operand_b[gnt_idx];
                wr_ptr <= wr_ptr + 1'b1;
                rr_last <= gnt_idx;
            end
            if (rd_state == RD_IDLE) begin
                if (rd_req && count != '0) begin
                    rd_state <= RD_ADDR;
                    ir_read_pointer <= rd_ptr;
                end
            end else begin
                rd_data <= ir_instruction_word;
                rd_addr <= rd_ptr;
                rd_valid <= 1'b1;
                rd_ptr <= rd_ptr + 1'b1;
                rd_state <= RD_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_instr_register_sched.sv
// tb_instr_register_sched: occupancy/FIFO reference model feeding expected loads and reads to a scoreboard
module tb_instr_register_sched;
    import instr_register_pkg::*;
    localparam int NR = 4;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0] req_valid, req_ready;
    opcode_t req_opcode [NR];
    operand_t req_operand_a [NR], req_operand_b [NR];
    logic rd_req, rd_valid, full, empty, ir_reset_n, ir_load_en;
    instruction_t rd_data, ir_instruction_word;
    address_t rd_addr, ir_write_pointer, ir_read_pointer;
    logic [5:0] count;
    opcode_t ir_opcode;
    operand_t ir_operand_a, ir_operand_b;

    always #5 clk = ~clk;

    instr_register_sched #(.NUM_REQ(NR), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_opcode(req_opcode),
        .req_operand_a(req_operand_a), .req_operand_b(req_operand_b), .req_ready(req_ready),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr),
        .count(count), .full(full), .empty(empty), .ir_reset_n(ir_reset_n),
        .ir_load_en(ir_load_en), .ir_write_pointer(ir_write_pointer), .ir_opcode(ir_opcode),
        .ir_operand_a(ir_operand_a), .ir_operand_b(ir_operand_b),
        .ir_read_pointer(ir_read_pointer), .ir_instruction_word(ir_instruction_word)
    );

    // stand-in for instr_register: write on load_en, combinational read
    instruction_t irmem [DEPTH];
    always @(posedge clk)
        if (ir_load_en === 1'b1) irmem[ir_write_pointer] <= '{opc: ir_opcode, op_a: ir_operand_a, op_b: ir_operand_b};
    assign ir_instruction_word = irmem[ir_read_pointer];

    typedef struct {
        int due;
        address_t addr;
        instruction_t ins;
    } exp_t;

    exp_t wq[$], rq[$], mem_q[$];
    exp_t m_pend_e;
    int checks = 0, errors = 0, cyc = 0, m_last;
    bit m_gate, m_pend, m_busy, mon_on = 1'b0;
    address_t m_wptr;
    opcode_t f_opc [NR];
    operand_t f_a [NR], f_b [NR];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        wq.delete(); rq.delete(); mem_q.delete();
        m_gate = 1'b0; m_pend = 1'b0; m_busy = 1'b0; m_last = NR - 1; m_wptr = '0;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NR; i++) begin
            f_opc[i] = opcode_t'($urandom_range(0, 7));
            f_a[i] = operand_t'($urandom);
            f_b[i] = operand_t'($urandom);
        end
    endtask

    // one clock cycle: drive, check occupancy-level outputs, advance the model
    task automatic step(input logic [NR-1:0] rv, input bit rq_in, input bit rst);
        int g;
        bit acc;
        exp_t e;
        @(negedge clk);
        #1;
        req_valid = rv; rd_req = rq_in; reset = rst;
        for (int i = 0; i < NR; i++) begin
            req_opcode[i] = f_opc[i]; req_operand_a[i] = f_a[i]; req_operand_b[i] = f_b[i];
        end
        #1;
        g = -1;
        if (!rst && m_gate && mem_q.size() + int'(m_pend) < DEPTH)
            for (int k = 1; k <= NR; k++)
                if (g < 0 && rv[(m_last + k) % NR]) g = (m_last + k) % NR;
        chk("req_ready", req_ready, g < 0 ? 0 : (1 << g));
        chk("count", count, mem_q.size());
        chk("empty", empty, mem_q.size() == 0);
        chk("full", full, mem_q.size() == DEPTH);
        chk("ir_reset_n", ir_reset_n, m_gate);
        acc = !rst && !m_busy && rq_in && mem_q.size() > 0;
        if (rst) model_reset();
        else begin
            if (acc) begin
                e = mem_q[0];
                e.due = cyc + 2;
                rq.push_back(e);
            end
            if (m_busy) void'(mem_q.pop_front());
            if (m_pend) mem_q.push_back(m_pend_e);
            m_busy = acc;
            m_pend = g >= 0;
            if (g >= 0) begin
                m_pend_e.due = cyc + 1;
                m_pend_e.addr = m_wptr;
                m_pend_e.ins.opc = f_opc[g];
                m_pend_e.ins.op_a = f_a[g];
                m_pend_e.ins.op_b = f_b[g];
                wq.push_back(m_pend_e);
                m_wptr++;
                m_last = g;
            end
            m_gate = 1'b1;
        end
    endtask

    task automatic do_reset();
        step('1, 1'b0, 1'b1);
        step('1, 1'b0, 1'b1);
    endtask

    // scoreboard: an output must appear exactly in the cycle the model scheduled it
    always @(negedge clk) begin
        exp_t e;
        bit exp_ld, exp_rd;
        if (mon_on) begin
            exp_ld = wq.size() > 0 && wq[0].due == cyc;
            chk("ir_load_en", ir_load_en, exp_ld);
            if (exp_ld) begin
                e = wq.pop_front();
                chk("ir_write_pointer", ir_write_pointer, e.addr);
                chk("ir_opcode", ir_opcode, e.ins.opc);
                chk("ir_operand_a", ir_operand_a, e.ins.op_a);
                chk("ir_operand_b", ir_operand_b, e.ins.op_b);
            end
            exp_rd = rq.size() > 0 && rq[0].due == cyc;
            chk("rd_valid", rd_valid, exp_rd);
            if (exp_rd) begin
                e = rq.pop_front();
                chk("rd_addr", rd_addr, e.addr);
                chk("rd_data.opc", rd_data.opc, e.ins.opc);
                chk("rd_data.op_a", rd_data.op_a, e.ins.op_a);
                chk("rd_data.op_b", rd_data.op_b, e.ins.op_b);
            end
        end
    end

    initial begin
        int wp;
        logic [NR-1:0] rv;
        reset = 1'b1; req_valid = '1; rd_req = 1'b0;
        rand_fields();
        for (int i = 0; i < NR; i++) begin
            req_opcode[i] = f_opc[i]; req_operand_a[i] = f_a[i]; req_operand_b[i] = f_b[i];
        end
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ir_reset_n", ir_reset_n, 0);
        chk("rst_ir_load_en", ir_load_en, 0);
        chk("rst_ir_write_pointer", ir_write_pointer, 0);
        chk("rst_ir_read_pointer", ir_read_pointer, 0);
        chk("rst_ir_opcode", ir_opcode, 0);
        chk("rst_ir_operand_a", ir_operand_a, 0);
        chk("rst_ir_operand_b", ir_operand_b, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_data_opc", rd_data.opc, 0);
        chk("rst_rd_data_a", rd_data.op_a, 0);
        chk("rst_rd_data_b", rd_data.op_b, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        mon_on = 1'b1;

        // release cycle then all requesters valid for 8 grants
        for (int n = 0; n < 9; n++) begin rand_fields(); step('1, 1'b0, 1'b0); end
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("count_after_8", count, 8);
        repeat (20) step('0, 1'b1, 1'b0);

        // single ADD from requester 2 read back
        do_reset();
        step('0, 1'b0, 1'b0);
        rand_fields();
        f_opc[2] = ADD; f_a[2] = 5; f_b[2] = 3;
        step(4'b0100, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("add_rd_valid", rd_valid, 1);
        chk("add_rd_addr", rd_addr, 0);
        chk("add_opc", rd_data.opc, ADD);
        chk("add_op_a", rd_data.op_a, 5);
        chk("add_op_b", rd_data.op_b, 3);
        chk("add_empty", empty, 1);

        // fill to full, hold requests, then one read frees one slot at address 0
        do_reset();
        step('0, 1'b0, 1'b0);
        for (int n = 0; n < 38; n++) begin rand_fields(); step('1, 1'b0, 1'b0); end
        chk("full_flag", full, 1);
        chk("full_no_load", ir_load_en, 0);
        chk("full_no_ready", req_ready, 0);
        step('1, 1'b1, 1'b0);
        step('1, 1'b0, 1'b0);
        rand_fields();
        step('1, 1'b0, 1'b0);
        step('1, 1'b0, 1'b0);
        chk("wrap_load_en", ir_load_en, 1);
        chk("wrap_ptr", ir_write_pointer, 0);

        // drain, then reads against an empty register
        repeat (70) step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("empty_no_rd_valid", rd_valid, 0);
        chk("empty_count", count, 0);

        // commit and read-decrement on the same edge at count 4
        do_reset();
        step('0, 1'b0, 1'b0);
        repeat (4) begin rand_fields(); step(4'b0001, 1'b0, 1'b0); end
        step('0, 1'b0, 1'b0);
        rand_fields();
        step(4'b0001, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("same_edge_count", count, 4);

        // reset while a read is in RD_ADDR and a load is pending
        do_reset();
        step('0, 1'b0, 1'b0);
        repeat (4) begin rand_fields(); step('1, 1'b0, 1'b0); end
        step('1, 1'b1, 1'b0);
        do_reset();
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_load_en", ir_load_en, 0);
        chk("midrst_count", count, 0);
        step('0, 1'b0, 1'b0);
        rand_fields();
        step('1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("midrst_load_after", ir_load_en, 1);
        chk("midrst_ptr_after", ir_write_pointer, 0);

        // random traffic with varying write density and rare resets
        wp = 2;
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) wp = $urandom_range(0, 4);
            rand_fields();
            rv = ($urandom_range(0, 3) < wp) ? NR'($urandom) : '0;
            step(rv, 1'($urandom_range(0, 1)), $urandom_range(0, 299) == 0);
        end
        repeat (10) step('0, 1'b0, 1'b0);
        chk("loads_outstanding", wq.size(), 0);
        chk("reads_outstanding", rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_register_sched.md
Name: instr_register_sched

Overview:
- Controller placed in front of instr_register. It shares the register's single write port among NUM_REQ requesters using round-robin arbitration.
- It allocates write addresses in ring order, tracks occupancy, and serves reads of committed entries oldest-first over a valid/ready-style read port.
- It owns all instr_register control signals: load_en, reset_n, write_pointer and read_pointer.

Parameters:
NUM_REQ, 4, number of write requesters (2..8)
DEPTH, 32, register entries; must equal 2**$bits(address_t)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  requester i has an instruction pending
req_opcode  in  NUM_REQ x opcode_t  per-requester opcode
req_operand_a  in  NUM_REQ x operand_t  per-requester operand A
req_operand_b  in  NUM_REQ x operand_t  per-requester operand B
req_ready  out  NUM_REQ  one-hot grant; handshake = req_valid[i] & req_ready[i]
rd_req  in  1  consumer requests the oldest committed entry
rd_valid  out  1  rd_data valid (single-cycle pulse)
rd_data  out  instruction_t  entry read back
rd_addr  out  address_t  address rd_data came from
count  out  $clog2(DEPTH)+1  committed, unread entries
full  out  1  count == DEPTH
empty  out  1  count == 0
ir_reset_n  out  1  to instr_register reset_n
ir_load_en  out  1  to instr_register load_en
ir_write_pointer  out  address_t  to instr_register
ir_opcode  out  opcode_t  to instr_register
ir_operand_a  out  operand_t  to instr_register
ir_operand_b  out  operand_t  to instr_register
ir_read_pointer  out  address_t  to instr_register
ir_instruction_word  in  instruction_t  from instr_register (combinational read of ir_read_pointer)

Behaviour:
- Reset values:
  - ir_reset_n=0, ir_load_en=0, all ir_* data and pointers=0.
  - req_ready=0, rd_valid=0, rd_data=0, rd_addr=0, count=0, empty=1, full=0.
  - Internal state: wr_ptr=0, rd_ptr=0, rr_last=NUM_REQ-1 (so requester 0 has first priority), read FSM=RD_IDLE.
- ir_reset_n is registered as ~reset. It is asserted on the first reset edge and releases one cycle after reset deasserts.
- Write arbitration (combinational):
  - Grant goes to the first i with req_valid[i] set, searching from rr_last+1 upward with wrap.
  - No grant while full, reset, or the cycle immediately after reset release.
- On handshake with requester g:
  - Next edge: ir_load_en=1, ir_write_pointer=wr_ptr, ir_opcode/ir_operand_a/ir_operand_b = requester g's fields.
  - Same edge: wr_ptr increments mod DEPTH and rr_last=g.
  - Without a handshake, ir_load_en=0 next edge and the data outputs hold.
  - At most one grant per cycle.
- Commit: count increments on the edge that ends a cycle with ir_load_en=1. That entry is readable from the following cycle.
- Full accounting counts entries in flight: full pre-checks (count + pending_load == DEPTH), so a grant never overwrites an unread entry.
- Read FSM:
  - RD_IDLE: on rd_req with count>0 → RD_ADDR, drive ir_read_pointer=rd_ptr. rd_req with count==0 is ignored (no error; the consumer must retry).
  - RD_ADDR (1 cycle): capture ir_instruction_word→rd_data and rd_ptr→rd_addr. Next edge rd_valid=1, rd_ptr++ mod DEPTH, count decrements → RD_IDLE.
  - Read latency is 2 cycles from rd_req sampled to rd_valid. Back-to-back reads issue at one every 2 cycles.
- Simultaneous commit and read-decrement on the same edge: count unchanged.
- Pointer wrap: 31→0 for both pointers, no gaps.
- Reset mid-operation: any in-flight load and read are discarded and all state returns to reset values. A grant given in the reset cycle is not honoured.

Decomposition:
- instr_register_pkg: opcode_t, operand_t, address_t, instruction_t are already there. Add rd_state_t enum {RD_IDLE, RD_ADDR} and constant IR_DEPTH=32.
- One sub-module: rr_arbiter, parameterised on NUM_REQ. Inputs: req, enable, last. Outputs: one-hot gnt and gnt_idx.

Test Plan:
- Reset held 2 cycles → all outputs at reset values, ir_reset_n=0. One cycle after release ir_reset_n=1, and no req_ready on that first cycle.
- All 4 requesters valid for 8 cycles → grants ordered 0,1,2,3,0,1,2,3. ir_write_pointer 0..7 on consecutive cycles with each winner's fields; count=8.
- Write ADD a=5 b=3 from req 2, then rd_req → rd_valid 2 cycles after rd_req with rd_addr=0, rd_data.opc=ADD, op_a=5, op_b=3; count back to 0, empty=1.
- 32 writes with no reads → full=1 and req_ready all 0. Hold req_valid 5 more cycles → no ir_load_en. One read → one more grant, written to address 0 after wrap.
- Read and commit on the same edge with count=4 → count stays 4. rd_req with empty → no rd_valid.
- Assert reset during RD_ADDR and with a pending load → no rd_valid, ir_load_en=0, count=0, next write goes to address 0.
